param_data_memory: RTL and testbench
====================================

PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH_BYTES, default 2048, byte capacity; a power of two and a multiple of DATA_W/8.
REQ-003 SHALL have parameter ADDR_W, default 11, byte-address width, equal to log2(DEPTH_BYTES).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-high reset (asserted = 1).
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-008 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  input  2  access size: 00 byte, 01 half, 10 word (32b), 11 double (64b).
REQ-010 SHALL have port req_unsigned  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-011 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-012 SHALL have port req_wdata  input  DATA_W  store data, right-justified.
REQ-013 SHALL have port clear_req  input  1  single-cycle pulse requesting a full memory clear.
REQ-014 SHALL have port rsp_valid  output  1  one-cycle pulse: load data or error valid.
REQ-015 SHALL have port rsp_rdata  output  DATA_W  load data, right-justified and extended.
REQ-016 SHALL have port rsp_err  output  1  request rejected as misaligned or illegal size.
REQ-017 SHALL have port busy  output  1  clear sequence in progress.

Function
REQ-018 SHALL implement FSM states CLEAR and IDLE; reset enters CLEAR with the word counter at 0.
REQ-019 In CLEAR SHALL write zero to one full word per cycle at the counter, then increment; after word DEPTH_BYTES/(DATA_W/8)-1 SHALL go to IDLE next cycle.
REQ-020 busy SHALL be 1 exactly while state is CLEAR; req_ready SHALL be (state==IDLE) && !clear_req, combinationally.
REQ-021 clear_req in IDLE SHALL move to CLEAR next cycle with counter 0; clear_req in CLEAR SHALL restart the counter at 0.
REQ-022 Simultaneous req_valid and clear_req SHALL leave the request unaccepted; clear wins.
REQ-023 Memory SHALL be byte-addressed little-endian: the byte at offset k of an access lives at req_addr+k.
REQ-024 Size 11 with DATA_W=32 SHALL be illegal; misaligned SHALL mean half with addr[0]=1, word with addr[1:0]!=0, or double with addr[2:0]!=0.
REQ-025 Accepted legal store SHALL write the low 1/2/4/8 bytes of req_wdata at that edge; no response pulse SHALL be issued.
REQ-026 Accepted illegal or misaligned access SHALL not modify memory and SHALL give rsp_valid=1, rsp_err=1, rsp_rdata=0 on the next cycle, for loads and stores alike.
REQ-027 Accepted legal load SHALL give rsp_valid=1, rsp_err=0 exactly one cycle later, with data extended per req_unsigned to DATA_W.
REQ-028 A load accepted the cycle after a store to the same bytes SHALL return the stored data.
REQ-029 Back-to-back loads SHALL be accepted every cycle, one response per cycle in order; no response backpressure exists.
REQ-030 rsp_valid SHALL be 0 in every cycle not required by REQ-026/027; rsp_rdata and rsp_err SHALL hold their last values while rsp_valid=0.
REQ-031 A load accepted in the cycle before clear_req SHALL still respond on the following cycle with pre-clear data.

Reset
REQ-032 Asserting reset_n SHALL immediately force rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1, req_ready=0, state CLEAR, counter 0.
REQ-033 Reset asserted mid-CLEAR or mid-traffic SHALL abort; any pending response SHALL be dropped; the clear SHALL restart from word 0 after release.
REQ-034 After reset release, busy SHALL stay 1 for exactly DEPTH_BYTES/(DATA_W/8) cycles (512 for the defaults), then req_ready SHALL rise.

Verification
REQ-035 Defaults, release reset -> busy high 512 cycles; then word load at 0x7FC -> rsp_rdata=0x00000000, rsp_err=0.
REQ-036 Store word 0x80FF7F01 at 0x010; byte loads 0x011 signed/unsigned -> 0x0000007F/0x0000007F; 0x013 signed -> 0xFFFFFF80; half 0x012 unsigned -> 0x000080FF.
REQ-037 Half store 0xBEEF at 0x021, then word load 0x022 -> both rsp_err=1, rsp_rdata=0; memory at 0x020-0x023 still 0.
REQ-038 Store at N, load same address at N+1, loads at N+2..N+5 to distinct addresses -> five consecutive rsp_valid pulses with correct in-order data.
REQ-039 clear_req together with req_valid -> req_ready=0 that cycle, busy next cycle, prior stores read back 0 after clear.
REQ-040 DATA_W=64, DEPTH_BYTES=4096: double store 0x0123456789ABCDEF at 0x008, double load -> same value; size 11 at 0x00C -> rsp_err=1.

Source files
------------

// File: rtl/param_data_memory.sv
// Byte-addressed little-endian data memory with aligned load/store, one-cycle
// load responses and a word-per-cycle hardware clear after reset or on request.
//
// state  | meaning
// CLEAR  | zeroing one word per cycle at clr_cnt; requests are refused
// IDLE   | accepting loads and stores
module param_data_memory #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_BYTES = 2048,
    parameter int ADDR_W      = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              clear_req,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int BPW    = DATA_W / 8;
    localparam int OFF_W  = $clog2(BPW);
    localparam int NWORDS = DEPTH_BYTES / BPW;
    localparam int CNT_W  = ADDR_W - OFF_W;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]  mem [NWORDS];

    logic [CNT_W-1:0]   word_idx;
    logic [OFF_W-1:0]   off;
    logic               illegal_size;
    logic               misaligned;
    logic               acc_err;
    logic               accept;
    logic               do_store;
    logic [DATA_W-1:0]  rd_shift;
    logic [DATA_W-1:0]  load_data;
    logic [DATA_W-1:0]  wdata_sh;
    logic [BPW-1:0]     byte_en;
    logic [3:0]         nbytes;

    assign busy      = (state == ST_CLEAR);
    assign req_ready = (state == ST_IDLE) && !clear_req;

    assign word_idx     = req_addr[ADDR_W-1:OFF_W];
    assign off          = req_addr[OFF_W-1:0];
    assign illegal_size = (req_size == 2'b11) && (DATA_W == 32);
    assign acc_err      = illegal_size || misaligned;
    assign accept       = req_valid && req_ready;
    assign do_store     = accept && req_write && !acc_err;
    assign nbytes       = 4'd1 << req_size;

    always_comb begin
        misaligned = 1'b0;
        unique case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            2'b11:   misaligned = (req_addr[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
    end

    // The read word is shifted so the addressed byte sits at bit 0, then extended.
    assign rd_shift = mem[word_idx] >> {off, 3'b000};

    always_comb begin
        load_data = rd_shift;
        unique case (req_size)
            2'b00: load_data = req_unsigned ? DATA_W'(rd_shift[7:0])
                                            : DATA_W'($signed(rd_shift[7:0]));
            2'b01: load_data = req_unsigned ? DATA_W'(rd_shift[15:0])
                                            : DATA_W'($signed(rd_shift[15:0]));
            2'b10: load_data = req_unsigned ? DATA_W'(rd_shift[31:0])
                                            : DATA_W'($signed(rd_shift[31:0]));
            default: load_data = rd_shift;
        endcase
    end

    assign wdata_sh = req_wdata << {off, 3'b000};

    always_comb begin
        byte_en = '0;
        for (int k = 0; k < BPW; k++) begin
            if ((k >= int'(off)) && (k < int'(off) + int'(nbytes)))
                byte_en[k] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (do_store) begin
            for (int k = 0; k < BPW; k++) begin
                if (byte_en[k])
                    mem[word_idx][8*k +: 8] <= wdata_sh[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            // Load data is captured at acceptance, so a clear that follows
            // cannot disturb a response already in flight.
            if (accept && (acc_err || !req_write)) begin
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_rdata <= acc_err ? '0 : load_data;
            end
            unique case (state)
                ST_CLEAR: begin
                    if (clear_req) begin
                        clr_cnt <= '0;
                    end else if (clr_cnt == CNT_W'(NWORDS - 1)) begin
                        clr_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        clr_cnt <= '0;
                        state   <= ST_CLEAR;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench for param_data_memory: a byte-array reference model checked every
// cycle on the default instance, plus literal expectations on both widths.
module tb_param_data_memory;

    localparam int NW = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        v, w, u, clr;
    logic [1:0]  sz;
    logic [10:0] a;
    logic [31:0] wd;
    logic        ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        q_v, q_w, q_u, q_clr;
    logic [1:0]  q_sz;
    logic [11:0] q_a;
    logic [63:0] q_wd;
    logic        q_ready, q_rv, q_re, q_busy;
    logic [63:0] q_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_data_memory dut (
        .clk(clk), .reset_n(rst), .req_valid(v), .req_ready(ready), .req_write(w),
        .req_size(sz), .req_unsigned(u), .req_addr(a), .req_wdata(wd),
        .clear_req(clr), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    param_data_memory #(.DATA_W(64), .DEPTH_BYTES(4096), .ADDR_W(12)) dut64 (
        .clk(clk), .reset_n(rst), .req_valid(q_v), .req_ready(q_ready), .req_write(q_w),
        .req_size(q_sz), .req_unsigned(q_u), .req_addr(q_a), .req_wdata(q_wd),
        .clear_req(q_clr), .rsp_valid(q_rv), .rsp_rdata(q_rd),
        .rsp_err(q_re), .busy(q_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory as plain bytes, clear as a remaining-cycle count.
    logic [7:0]  m_mem [2048];
    int          clear_left;
    logic        m_valid, m_err;
    logic [31:0] m_rdata;
    int          m_n;
    logic [63:0] m_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_left = NW;
            m_valid = 1'b0; m_err = 1'b0; m_rdata = '0;
            for (int i = 0; i < 2048; i++) m_mem[i] = 8'h00;
        end else begin
            m_valid = 1'b0;
            if (v && clear_left == 0 && !clr) begin
                m_n = 1 << sz;
                if (sz == 2'd3 || (int'(a) % m_n) != 0) begin
                    m_valid = 1'b1; m_err = 1'b1; m_rdata = '0;
                end else if (w) begin
                    for (int k = 0; k < m_n; k++) m_mem[int'(a) + k] = wd[8*k +: 8];
                end else begin
                    m_val = '0;
                    for (int k = 0; k < m_n; k++) m_val[8*k +: 8] = m_mem[int'(a) + k];
                    if (!u)
                        for (int b = 8 * m_n; b < 64; b++) m_val[b] = m_val[8*m_n-1];
                    m_valid = 1'b1; m_err = 1'b0; m_rdata = m_val[31:0];
                end
            end
            if (clr) begin
                clear_left = NW;
                for (int i = 0; i < 2048; i++) m_mem[i] = 8'h00;
            end else if (clear_left > 0) begin
                clear_left--;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc.rsp_valid", rsp_valid, m_valid);
        chk("cyc.rsp_err", rsp_err, m_err);
        chk("cyc.rsp_rdata", rsp_rdata, m_rdata);
        chk("cyc.busy", busy, clear_left > 0);
        chk("cyc.req_ready", ready, (clear_left == 0) && !clr);
    end

    task automatic step(input logic vv, input logic ww, input logic [1:0] s, input logic uu,
                        input logic [10:0] aa, input logic [31:0] dd, input logic cc);
        v = vv; w = ww; sz = s; u = uu; a = aa; wd = dd; clr = cc;
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'd0, 0, 11'h0, 32'h0, 0);
    endtask

    task automatic step64(input logic vv, input logic ww, input logic [1:0] s, input logic uu,
                          input logic [11:0] aa, input logic [63:0] dd);
        q_v = vv; q_w = ww; q_sz = s; q_u = uu; q_a = aa; q_wd = dd; q_clr = 1'b0;
        @(negedge clk); #1;
        q_v = 1'b0;
    endtask

    task automatic chk_rsp(input string nm, input logic ev, input logic ee, input logic [31:0] ed);
        chk({nm, ".valid"}, rsp_valid, ev);
        chk({nm, ".err"}, rsp_err, ee);
        chk({nm, ".rdata"}, rsp_rdata, ed);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    int n;

    initial begin
        rst = 1'b1;
        v = 0; w = 0; u = 0; clr = 0; sz = 0; a = 0; wd = 0;
        q_v = 0; q_w = 0; q_u = 0; q_clr = 0; q_sz = 0; q_a = 0; q_wd = 0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        wait_idle(n);
        chk("busy_cycles_after_reset", n, 512);
        chk("dut64_idle", q_busy, 1'b0);

        step(1, 0, 2'd2, 0, 11'h7FC, 32'h0, 0);
        chk_rsp("ld_7fc", 1, 0, 32'h0);

        step(1, 1, 2'd2, 0, 11'h010, 32'h80FF7F01, 0);
        step(1, 0, 2'd0, 0, 11'h011, 32'h0, 0);
        chk_rsp("ldb_011_s", 1, 0, 32'h0000007F);
        step(1, 0, 2'd0, 1, 11'h011, 32'h0, 0);
        chk_rsp("ldb_011_u", 1, 0, 32'h0000007F);
        step(1, 0, 2'd0, 0, 11'h013, 32'h0, 0);
        chk_rsp("ldb_013_s", 1, 0, 32'hFFFFFF80);
        step(1, 0, 2'd1, 1, 11'h012, 32'h0, 0);
        chk_rsp("ldh_012_u", 1, 0, 32'h000080FF);
        idle(1);

        step(1, 1, 2'd1, 0, 11'h021, 32'h0000BEEF, 0);
        chk_rsp("sth_021_mis", 1, 1, 32'h0);
        step(1, 0, 2'd2, 0, 11'h022, 32'h0, 0);
        chk_rsp("ldw_022_mis", 1, 1, 32'h0);
        step(1, 0, 2'd2, 0, 11'h020, 32'h0, 0);
        chk_rsp("ldw_020_untouched", 1, 0, 32'h0);
        step(1, 1, 2'd3, 0, 11'h000, 32'h1234, 0);
        chk_rsp("st_size3_illegal", 1, 1, 32'h0);
        idle(1);

        step(1, 1, 2'd2, 0, 11'h100, 32'hCAFEBABE, 0);
        step(1, 0, 2'd2, 0, 11'h100, 32'h0, 0);
        chk_rsp("b2b_0", 1, 0, 32'hCAFEBABE);
        step(1, 0, 2'd0, 1, 11'h010, 32'h0, 0);
        chk_rsp("b2b_1", 1, 0, 32'h00000001);
        step(1, 0, 2'd1, 0, 11'h012, 32'h0, 0);
        chk_rsp("b2b_2", 1, 0, 32'hFFFF80FF);
        step(1, 0, 2'd0, 1, 11'h013, 32'h0, 0);
        chk_rsp("b2b_3", 1, 0, 32'h00000080);
        step(1, 0, 2'd1, 1, 11'h102, 32'h0, 0);
        chk_rsp("b2b_4", 1, 0, 32'h0000CAFE);
        idle(1);
        chk("rsp_hold_after_pulse", rsp_rdata, 32'h0000CAFE);

        for (int i = 0; i < 12; i++)
            step(1, 1, 2'(i % 3), 0, 11'(11'h200 + 4 * i), 32'h9E3779B9 * (i + 1), 0);
        for (int i = 0; i < 12; i++)
            for (int s = 0; s < 3; s++) begin
                step(1, 0, 2'(s), i[0], 11'(11'h200 + 4 * i), 32'h0, 0);
                step(1, 0, 2'(s), i[1], 11'(11'h201 + 4 * i + s), 32'h0, 0);
            end
        idle(1);

        step64(1, 1, 2'd3, 0, 12'h008, 64'h0123456789ABCDEF);
        step64(1, 0, 2'd3, 1, 12'h008, 64'h0);
        chk("d64_ld_double", q_rd, 64'h0123456789ABCDEF);
        chk("d64_ld_double_err", q_re, 1'b0);
        step64(1, 0, 2'd3, 0, 12'h00C, 64'h0);
        chk("d64_mis_double_err", q_re, 1'b1);
        chk("d64_mis_double_data", q_rd, 64'h0);
        step64(1, 0, 2'd2, 0, 12'h00C, 64'h0);
        chk("d64_ldw_hi", q_rd, 64'h0000000001234567);
        step64(1, 0, 2'd2, 0, 12'h008, 64'h0);
        chk("d64_ldw_lo_sext", q_rd, 64'hFFFFFFFF89ABCDEF);

        step(1, 1, 2'd2, 0, 11'h040, 32'h12345678, 0);
        step(1, 0, 2'd2, 0, 11'h040, 32'h0, 0);
        chk_rsp("ld_before_clear", 1, 0, 32'h12345678);
        v = 1; w = 0; sz = 2'd2; a = 11'h040; clr = 1;
        #1 chk("ready_low_on_clear", ready, 1'b0);
        @(negedge clk); #1;
        chk("busy_after_clear", busy, 1'b1);
        chk("no_rsp_clear_wins", rsp_valid, 1'b0);
        v = 0; clr = 0;
        wait_idle(n);
        chk("busy_cycles_after_clear", n, 512);
        step(1, 0, 2'd2, 0, 11'h040, 32'h0, 0);
        chk_rsp("ld_040_cleared", 1, 0, 32'h0);
        step(1, 0, 2'd2, 0, 11'h100, 32'h0, 0);
        chk_rsp("ld_100_cleared", 1, 0, 32'h0);

        step(1, 1, 2'd2, 0, 11'h010, 32'hFFFFFFFF, 0);
        step(1, 0, 2'd2, 0, 11'h010, 32'h0, 0);
        v = 1; w = 0; sz = 2'd2; a = 11'h010;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ready", ready, 1'b0);
        v = 0;
        @(negedge clk); #1 rst = 1'b0;
        idle(100);
        rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        wait_idle(n);
        chk("busy_cycles_after_mid_clear_reset", n, 512);
        step(1, 0, 2'd2, 0, 11'h010, 32'h0, 0);
        chk_rsp("ld_010_after_reset", 1, 0, 32'h0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
